// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: PLL divider reconfiguration controller.
// Sequences PLL reset around divider changes and debounces lock.
module pll_dyn_ctrl #(
  parameter logic [5:0] DEF_IDIV     = 6'd5,
  parameter logic [5:0] DEF_FDIV     = 6'd12,
  parameter logic [5:0] DEF_ODSEL    = 6'd8,
  parameter int         RESET_CYCLES = 16,
  parameter int         LOCK_STABLE  = 8,
  parameter int         LOCK_TIMEOUT = 65535
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv,
  input  logic [5:0] req_fdiv,
  input  logic [5:0] req_odsel,
  output logic [5:0] idiv,
  output logic [5:0] fdiv,
  output logic [5:0] odiv,
  output logic       pll_reset,
  output logic       pll_reset_p,
  input  logic       lock_i,
  output logic       locked,
  output logic       busy,
  output logic       err_timeout,
  output logic       lock_lost
);

  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  STABLE   = 8'(LOCK_STABLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_WAIT,
    S_LOCKED
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [7:0]  r_stable;
  logic        r_sync1;
  logic        r_lock_s;
  logic [5:0]  r_idiv;
  logic [5:0]  r_fdiv;
  logic [5:0]  r_odsel;
  logic        w_lock_ok;
  logic        w_load;
  logic        w_tmo;
  logic        w_lost;
  logic        w_enter_wait;
  logic        w_pll_reset;
  logic        w_locked;
  logic        w_busy;

  assign w_lock_ok   = (r_stable >= STABLE);
  assign idiv        = ~r_idiv;
  assign fdiv        = ~r_fdiv;
  assign odiv        = r_odsel;
  assign pll_reset_p = 1'b0;

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= lock_i;
      r_lock_s <= r_sync1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_tmo  = 1'b0;
    w_lost = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): w_next = S_RESET;
      (r_state == S_RESET): begin
        if (r_cnt == RST_LAST)
          w_next = S_WAIT;
      end
      (r_state == S_WAIT): begin
        if (w_lock_ok) begin
          w_next = S_LOCKED;
        end else if (r_cnt == TO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_RESET;
        end
      end
      (r_state == S_LOCKED): begin
        // Lock loss outranks a request arriving in the same cycle.
        if (!r_lock_s) begin
          w_lost = 1'b1;
          w_next = S_RESET;
        end else if (req_valid) begin
          w_load = 1'b1;
          w_next = S_RESET;
        end
      end
      default: w_next = S_RESET;
    endcase
  end

  assign w_enter_wait = (r_state == S_RESET) && (w_next == S_WAIT);

  always_ff @(posedge clkin) begin
    if (reset)
      r_stable <= '0;
    else if (!r_lock_s || w_enter_wait)
      r_stable <= '0;
    else if (r_stable != 8'hFF)
      r_stable <= r_stable + 8'd1;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_idiv  <= DEF_IDIV;
      r_fdiv  <= DEF_FDIV;
      r_odsel <= DEF_ODSEL;
    end else if (w_load) begin
      r_idiv  <= req_idiv;
      r_fdiv  <= req_fdiv;
      r_odsel <= req_odsel;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    w_pll_reset = (w_next == S_RESET);
    w_locked    = (w_next == S_LOCKED);
    w_busy      = (w_next != S_LOCKED);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      pll_reset   <= 1'b1;
      locked      <= 1'b0;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
      err_timeout <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      pll_reset   <= w_pll_reset;
      locked      <= w_locked;
      req_ready   <= w_locked;
      busy        <= w_busy;
      err_timeout <= w_tmo;
      lock_lost   <= w_lost;
    end
  end

endmodule

// File: doc/pll_dyn_ctrl.md
# pll_dyn_ctrl

Dynamic reconfiguration controller sitting directly upstream of the PLLVR wrapper with dynamic dividers. It holds the IDSEL/FBDSEL/ODSEL codes and drives the wrapper's `fdiv`/`idiv`/`odiv` inputs. It sequences the PLL reset around every divider change, synchronises the PLL `lock_o` output, and reports a debounced `locked` status. It retries automatically on lock timeout or lock loss.

## Interface
- `DEF_IDIV`, 5: power-on input divider minus one (0..63).
- `DEF_FDIV`, 12: power-on feedback divider minus one (0..63).
- `DEF_ODSEL`, 6'd8: power-on ODSEL code, passed through unencoded.
- `RESET_CYCLES`, 16: cycles `pll_reset` is held per sequence (2..255).
- `LOCK_STABLE`, 8: consecutive synced-lock cycles before `locked` asserts (1..255).
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK before retry (16-bit counter).

Ports:
- `clkin` in 1: free-running reference clock (same net as PLL CLKIN).
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: new divider request.
- `req_ready` out 1: high in IDLE and LOCKED only.
- `req_idiv` in 6: input divider minus one.
- `req_fdiv` in 6: feedback divider minus one.
- `req_odsel` in 6: ODSEL code.
- `idiv` out 6: to PLL IDSEL, equals `~idiv_value`.
- `fdiv` out 6: to PLL FBDSEL, equals `~fdiv_value`.
- `odiv` out 6: to PLL ODSEL, equals `odsel_value`.
- `pll_reset` out 1: to PLL RESET.
- `pll_reset_p` out 1: to PLL RESET_P, constant 0.
- `lock_i` in 1: PLL `lock_o`, asynchronous.
- `locked` out 1: debounced lock status.
- `busy` out 1: high whenever state is not LOCKED.
- `err_timeout` out 1: one-cycle pulse per lock timeout.
- `lock_lost` out 1: one-cycle pulse when lock drops while in LOCKED.

## Operation
- `lock_i` passes through a 2-flop synchroniser (`lock_s`). The synchroniser flops reset to 0.
- The stable counter clears whenever `lock_s`=0 and increments, saturating, while `lock_s`=1. `lock_ok` = (count ≥ LOCK_STABLE).
- States: IDLE, RESET, WAIT_LOCK, LOCKED. IDLE is entered only from `reset`.
- Under `reset`:
  - Divider registers load DEF_* values.
  - State goes to RESET with the counter cleared. Power-on sequencing is therefore automatic; IDLE is transient for 0 cycles.
- RESET:
  - `pll_reset`=1 and the counter increments.
  - After RESET_CYCLES cycles, go to WAIT_LOCK with the counter and stable counter cleared.
- WAIT_LOCK:
  - `pll_reset`=0 and the timeout counter increments.
  - If `lock_ok`, go to LOCKED.
  - Else if the counter reaches LOCK_TIMEOUT-1, pulse `err_timeout` and go to RESET, keeping the same divider values.
- LOCKED:
  - `locked`=1 and `req_ready`=1.
  - If `lock_s`=0, pulse `lock_lost` and go to RESET. This takes priority over a request in the same cycle; the request is not accepted, because `req_ready` drops the next cycle.
  - Else if `req_valid`, accept the request.
- Accept: on a cycle with `req_valid & req_ready`:
  - Load `req_*` into the divider registers.
  - Go to RESET with the counter cleared.
  - `locked` drops.
- Divider outputs change only on accept or `reset`, and always in the same cycle that `pll_reset` rises.
- Encoding: `idiv` = 63-`idiv_value` and `fdiv` = 63-`fdiv_value` (bitwise invert, 6-bit). `odiv` is not transformed.

## Timing
- Reset values:
  - `pll_reset`=1, `pll_reset_p`=0.
  - `idiv`=~DEF_IDIV, `fdiv`=~DEF_FDIV, `odiv`=DEF_ODSEL.
  - `locked`=0, `req_ready`=0, `busy`=1, `err_timeout`=0, `lock_lost`=0.
- Request accepted at edge T:
  - At T+1: new `idiv`/`fdiv`/`odiv` and `pll_reset`=1, `locked`=0, `busy`=1.
  - `pll_reset` stays high for exactly RESET_CYCLES cycles, then falls.
- Once `lock_i` rises and stays high, `locked` asserts 2 (sync) + LOCK_STABLE + 1 cycles later.
- `lock_i` low in LOCKED: `lock_lost` pulses 3 cycles later (2 sync + 1 decision), and `pll_reset` rises in the same cycle as the pulse.
- All outputs are registered. `req_ready` equals (state==LOCKED), registered.
- Mid-sequence `reset`: takes effect at the next edge and restarts the power-on sequence with DEF_* values.

## Test plan
- Power-on:
  - Stimulus: reset for 4 cycles with defaults, then `lock_i`=1 from cycle 40.
  - Required: `idiv`=6'd58, `fdiv`=6'd51, `odiv`=8, and `pll_reset` high for 16 cycles after reset release.
  - Required: `locked` rises at cycle 40+11.
- Reconfigure:
  - Stimulus: in LOCKED, request idiv=2, fdiv=9, odsel=4.
  - Required: outputs 61/54/4 and `pll_reset`=1 one cycle after accept, `locked` drops, and `req_ready`=0 until relock.
- Timeout:
  - Stimulus: LOCK_TIMEOUT=32, `lock_i` held 0.
  - Required: `err_timeout` pulses every 16+32 cycles, and dividers are unchanged.
- Lock loss:
  - Stimulus: drop `lock_i` for 1 cycle while LOCKED, with `req_valid` asserted simultaneously.
  - Required: `lock_lost` pulses once, the request is not accepted (dividers unchanged), and the controller relocks.
- Glitchy lock:
  - Stimulus: LOCK_STABLE=8, `lock_i` toggling 5 high / 1 low.
  - Required: `locked` never asserts.
- Mid-sequence reset:
  - Stimulus: assert `reset` during WAIT_LOCK after a custom request.
  - Required: dividers return to DEF_* and `pll_reset`=1 on the next edge.
